// File: rtl/ds2_responder.sv
`default_nettype none
// ============================================================================
//  Module   : ds2_responder
//  Purpose  : DualShock (PS2) pad emulator that answers host polls from a
//             12-bit SNES button vector. Define DS2_ANALOG_EN for the analog
//             pad frame (ID 0x73, 9 bytes).
//  Revision : 1.0  initial release
// ============================================================================
module ds2_responder #(
    parameter int FREQ      = 21_600_000,
    parameter int ACK_DELAY = FREQ / 500_000,
    parameter int ACK_WIDTH = FREQ / 500_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] snes_buttons,
    input  logic        ds_cs,
    input  logic        ds_clk,
    input  logic        ds_mosi,
    output logic        ds_miso,
    output logic        ds_miso_oe,
    output logic        ds_ack
);

`ifdef DS2_ANALOG_EN
    localparam logic [7:0] PAD_ID    = 8'h73;
    localparam logic [3:0] FRAME_LEN = 4'd9;
`else
    localparam logic [7:0] PAD_ID    = 8'h41;
    localparam logic [3:0] FRAME_LEN = 4'd5;
`endif

    localparam int TMAX = (ACK_DELAY > ACK_WIDTH) ? ACK_DELAY : ACK_WIDTH;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] DLY_LAST = TW'(ACK_DELAY - 1);
    localparam logic [TW-1:0] WID_LAST = TW'(ACK_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SHIFT, S_ACK_WAIT, S_ACK_PULSE, S_DONE, S_IGNORE
    } state_t;

    state_t          r_state, w_state_next;
    logic [1:0]      r_cs_sync, r_clk_sync, r_mosi_sync;
    logic            r_cs_q, r_clk_q;
    logic [7:0]      r_tx, r_b0, r_b1;
    logic [6:0]      r_rx;
    logic [3:0]      r_bit_cnt, r_byte_idx;
    logic [TW-1:0]   r_timer;
    logic            w_cs_fall, w_cs_rise, w_clk_fall, w_clk_rise;
    logic            w_start, w_next_byte, w_rx_take, w_tx_shift, w_timer_clr;
    logic            w_cmd_ok;
    logic [7:0]      w_rx_byte, w_snap_b0, w_snap_b1;

    function automatic logic [7:0] frame_byte(input logic [3:0] idx,
                                              input logic [7:0] b0,
                                              input logic [7:0] b1);
        logic [7:0] v;
        v = 8'hFF;
        case (idx)
            4'd1:    v = PAD_ID;
            4'd2:    v = 8'h5A;
            4'd3:    v = b0;
            4'd4:    v = b1;
            default: v = (idx >= 4'd5 && idx < FRAME_LEN) ? 8'h80 : 8'hFF;
        endcase
        return v;
    endfunction

    // ATT chain resets low so a bus that is already low after reset never
    // looks like a fresh falling edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cs_sync   <= 2'b00;
            r_cs_q      <= 1'b0;
            r_clk_sync  <= 2'b11;
            r_clk_q     <= 1'b1;
            r_mosi_sync <= 2'b11;
        end else begin
            r_cs_sync   <= {r_cs_sync[0], ds_cs};
            r_cs_q      <= r_cs_sync[1];
            r_clk_sync  <= {r_clk_sync[0], ds_clk};
            r_clk_q     <= r_clk_sync[1];
            r_mosi_sync <= {r_mosi_sync[0], ds_mosi};
        end
    end

    assign w_cs_fall  =  r_cs_q  & ~r_cs_sync[1];
    assign w_cs_rise  = ~r_cs_q  &  r_cs_sync[1];
    assign w_clk_fall =  r_clk_q & ~r_clk_sync[1];
    assign w_clk_rise = ~r_clk_q &  r_clk_sync[1];

    assign w_rx_byte = {r_mosi_sync[1], r_rx};
    assign w_cmd_ok  = !((r_byte_idx == 4'd0 && w_rx_byte != 8'h01) ||
                         (r_byte_idx == 4'd1 && w_rx_byte != 8'h42));

    assign w_snap_b0 = ~{snes_buttons[6], snes_buttons[5], snes_buttons[7],
                         snes_buttons[4], snes_buttons[3], 2'b00, snes_buttons[2]};
    assign w_snap_b1 = ~{snes_buttons[1], snes_buttons[0], snes_buttons[8],
                         snes_buttons[9], snes_buttons[11], snes_buttons[10], 2'b00};

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_next_byte  = 1'b0;
        w_rx_take    = 1'b0;
        w_tx_shift   = 1'b0;
        w_timer_clr  = 1'b0;
        if (w_cs_rise) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_cs_fall) begin
                        w_start      = 1'b1;
                        w_state_next = S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (w_clk_rise) begin
                        w_rx_take = 1'b1;
                        if (r_bit_cnt == 4'd7) begin
                            w_timer_clr = 1'b1;
                            if (!w_cmd_ok)                          w_state_next = S_IGNORE;
                            else if (r_byte_idx == FRAME_LEN - 4'd1) w_state_next = S_DONE;
                            else                                    w_state_next = S_ACK_WAIT;
                        end
                    // The first falling edge of a byte precedes bit 0, which is already on DAT.
                    end else if (w_clk_fall && r_bit_cnt != 4'd0) begin
                        w_tx_shift = 1'b1;
                    end
                end
                S_ACK_WAIT, S_ACK_PULSE: begin
                    if (w_clk_rise || w_clk_fall) begin
                        w_next_byte  = 1'b1;
                        w_rx_take    = w_clk_rise;
                        w_state_next = S_SHIFT;
                    end else if (r_state == S_ACK_WAIT && r_timer == DLY_LAST) begin
                        w_timer_clr  = 1'b1;
                        w_state_next = S_ACK_PULSE;
                    end else if (r_state == S_ACK_PULSE && r_timer == WID_LAST) begin
                        w_next_byte  = 1'b1;
                        w_state_next = S_SHIFT;
                    end
                end
                default: ;
            endcase
        end

        ds_ack     = (r_state != S_ACK_PULSE);
        ds_miso_oe = (r_state == S_SHIFT) || (r_state == S_ACK_WAIT) ||
                     (r_state == S_ACK_PULSE) || (r_state == S_DONE);
        ds_miso    = ds_miso_oe ? r_tx[0] : 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx       <= 8'hFF;
            r_rx       <= '0;
            r_bit_cnt  <= '0;
            r_byte_idx <= '0;
            r_timer    <= '0;
            r_b0       <= 8'hFF;
            r_b1       <= 8'hFF;
        end else begin
            if (w_start) begin
                r_b0       <= w_snap_b0;
                r_b1       <= w_snap_b1;
                r_tx       <= 8'hFF;
                r_byte_idx <= '0;
            end else if (w_next_byte) begin
                r_tx       <= frame_byte(r_byte_idx + 4'd1, r_b0, r_b1);
                r_byte_idx <= r_byte_idx + 4'd1;
            end else if (w_tx_shift) begin
                r_tx <= {1'b1, r_tx[7:1]};
            end

            if (w_start || w_next_byte) r_bit_cnt <= {3'd0, w_rx_take};
            else if (w_rx_take)         r_bit_cnt <= r_bit_cnt + 4'd1;

            if (w_rx_take) r_rx <= w_rx_byte[7:1];

            if (w_timer_clr) r_timer <= '0;
            else             r_timer <= r_timer + TW'(1);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ds2_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ds2_responder
//  Purpose  : Directed bench for ds2_responder acting as a PS2 host.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ds2_responder;

    localparam int FREQ      = 21_600_000;
    localparam int ACK_DELAY = FREQ / 500_000;
    localparam int ACK_WIDTH = FREQ / 500_000;
    localparam int HALF      = 5;
`ifdef DS2_ANALOG_EN
    localparam logic [7:0] ID = 8'h73;
    localparam int NB = 9;
`else
    localparam logic [7:0] ID = 8'h41;
    localparam int NB = 5;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] snes_buttons;
    logic        ds_cs, ds_clk, ds_mosi;
    logic        ds_miso, ds_miso_oe, ds_ack;

    int checks = 0;
    int errors = 0;

    logic [7:0] cmd_v [0:8];
    logic [7:0] resp [0:8];
    bit         ack_seen [0:8];
    int         ack_d [0:8];
    int         ack_w [0:8];
    logic       oe_after [0:8];
    int         early_idx = -1;
    int         chg_idx = -1;
    logic [11:0] chg_val = 12'h000;

    ds2_responder #(.FREQ(FREQ), .ACK_DELAY(ACK_DELAY), .ACK_WIDTH(ACK_WIDTH)) dut (
        .clk(clk), .reset(reset), .snes_buttons(snes_buttons),
        .ds_cs(ds_cs), .ds_clk(ds_clk), .ds_mosi(ds_mosi),
        .ds_miso(ds_miso), .ds_miso_oe(ds_miso_oe), .ds_ack(ds_ack)
    );

    always #5 clk = ~clk;

    task automatic std_cmd();
        for (int i = 0; i < 9; i++) cmd_v[i] = 8'h00;
        cmd_v[0] = 8'h01;
        cmd_v[1] = 8'h42;
    endtask

    task automatic xfer_bits(input logic [7:0] cmd, input int nbits, output logic [7:0] dat);
        dat = 8'hFF;
        for (int b = 0; b < nbits; b++) begin
            @(negedge clk);
            ds_clk  = 1'b0;
            ds_mosi = cmd[b];
            repeat (HALF) @(negedge clk);
            dat[b] = ds_miso;
            ds_clk = 1'b1;
            if (b < nbits - 1) repeat (HALF - 1) @(negedge clk);
        end
    endtask

    task automatic wait_ack(output bit seen, output int dly, output int width);
        seen = 1'b0; dly = 0; width = 0;
        for (int i = 0; i < ACK_DELAY + 12 && !seen; i++) begin
            @(negedge clk);
            if (ds_ack === 1'b0) begin seen = 1'b1; dly = i + 1; end
        end
        if (seen) begin
            width = 1;
            while (ds_ack === 1'b0 && width < ACK_WIDTH + 20) begin
                @(negedge clk);
                if (ds_ack === 1'b0) width++;
            end
        end
    endtask

    task automatic run_poll();
        logic [7:0] d;
        @(negedge clk);
        ds_cs = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < NB; i++) begin
            xfer_bits(cmd_v[i], 8, d);
            resp[i] = d;
            if (i == early_idx) begin
                repeat (10) @(negedge clk);
                ack_seen[i] = 1'b0; ack_d[i] = 0; ack_w[i] = 0;
            end else begin
                wait_ack(ack_seen[i], ack_d[i], ack_w[i]);
            end
            oe_after[i] = ds_miso_oe;
            if (i == chg_idx) snes_buttons = chg_val;
        end
        repeat (HALF) @(negedge clk);
        ds_cs = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (ds_miso !== 1'b1)    begin errors++; $display("FAIL reset_miso got %b want 1", ds_miso); end
        checks++; if (ds_miso_oe !== 1'b0) begin errors++; $display("FAIL reset_oe got %b want 0", ds_miso_oe); end
        checks++; if (ds_ack !== 1'b1)     begin errors++; $display("FAIL reset_ack got %b want 1", ds_ack); end
        reset = 1'b0;
        repeat (10) @(negedge clk);
        checks++; if (ds_miso_oe !== 1'b0) begin errors++; $display("FAIL idle_oe got %b want 0", ds_miso_oe); end
    endtask

    task automatic test_idle_poll();
        logic [7:0] exp [0:8];
        int nacks;
        exp = '{8'hFF, ID, 8'h5A, 8'hFF, 8'hFF, 8'h80, 8'h80, 8'h80, 8'h80};
        snes_buttons = 12'h000;
        std_cmd();
        run_poll();
        nacks = 0;
        for (int i = 0; i < NB; i++) begin
            checks++; if (resp[i] !== exp[i]) begin errors++; $display("FAIL idle_dat[%0d] got %h want %h", i, resp[i], exp[i]); end
            checks++; if (ack_seen[i] !== (i < NB - 1)) begin errors++; $display("FAIL idle_ack[%0d] got %0d want %0d", i, ack_seen[i], (i < NB - 1)); end
            if (ack_seen[i]) begin
                nacks++;
                checks++; if (ack_w[i] != ACK_WIDTH) begin errors++; $display("FAIL idle_ackw[%0d] got %0d want %0d", i, ack_w[i], ACK_WIDTH); end
            end
        end
        checks++; if (nacks != NB - 1) begin errors++; $display("FAIL idle_nacks got %0d want %0d", nacks, NB - 1); end
        checks++;
        if (ack_d[0] < ACK_DELAY + 3 || ack_d[0] > ACK_DELAY + 6) begin
            errors++; $display("FAIL idle_ackdly got %0d want %0d..%0d", ack_d[0], ACK_DELAY + 3, ACK_DELAY + 6);
        end
        checks++; if (oe_after[0] !== 1'b1) begin errors++; $display("FAIL idle_oe0 got %b want 1", oe_after[0]); end
    endtask

    task automatic test_button_mapping();
        logic [7:0] eb0 [0:11];
        logic [7:0] eb1 [0:11];
        eb0 = '{8'hFF, 8'hFF, 8'hFE, 8'hF7, 8'hEF, 8'hBF, 8'h7F, 8'hDF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        eb1 = '{8'hBF, 8'h7F, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hDF, 8'hEF, 8'hFB, 8'hF7};
        std_cmd();
        snes_buttons = 12'h811;
        run_poll();
        checks++; if (resp[3] !== 8'hEF) begin errors++; $display("FAIL map811_b0 got %h want ef", resp[3]); end
        checks++; if (resp[4] !== 8'hB7) begin errors++; $display("FAIL map811_b1 got %h want b7", resp[4]); end
        for (int k = 0; k < 12; k++) begin
            snes_buttons = 12'h001 << k;
            run_poll();
            checks++; if (resp[3] !== eb0[k]) begin errors++; $display("FAIL walk_b0[%0d] got %h want %h", k, resp[3], eb0[k]); end
            checks++; if (resp[4] !== eb1[k]) begin errors++; $display("FAIL walk_b1[%0d] got %h want %h", k, resp[4], eb1[k]); end
        end
        snes_buttons = 12'h000;
    endtask

    task automatic test_bad_address();
        int nacks;
        std_cmd();
        cmd_v[0] = 8'h81;
        run_poll();
        nacks = 0;
        for (int i = 0; i < NB; i++) if (ack_seen[i]) nacks++;
        checks++; if (nacks != 0) begin errors++; $display("FAIL bad_addr_acks got %0d want 0", nacks); end
        checks++; if (oe_after[0] !== 1'b0) begin errors++; $display("FAIL bad_addr_oe got %b want 0", oe_after[0]); end
        checks++; if (resp[2] !== 8'hFF) begin errors++; $display("FAIL bad_addr_dat2 got %h want ff", resp[2]); end
        std_cmd();
        cmd_v[1] = 8'h43;
        run_poll();
        checks++; if (ack_seen[0] !== 1'b1) begin errors++; $display("FAIL bad_cmd_ack0 got %0d want 1", ack_seen[0]); end
        checks++; if (ack_seen[1] !== 1'b0) begin errors++; $display("FAIL bad_cmd_ack1 got %0d want 0", ack_seen[1]); end
        checks++; if (oe_after[1] !== 1'b0) begin errors++; $display("FAIL bad_cmd_oe got %b want 0", oe_after[1]); end
        std_cmd();
        run_poll();
        checks++; if (resp[1] !== ID)   begin errors++; $display("FAIL recover_id got %h want %h", resp[1], ID); end
        checks++; if (ack_seen[3] !== 1'b1) begin errors++; $display("FAIL recover_ack3 got %0d want 1", ack_seen[3]); end
    endtask

    task automatic test_snapshot();
        std_cmd();
        snes_buttons = 12'h000;
        chg_idx = 2;
        chg_val = 12'hFFF;
        run_poll();
        chg_idx = -1;
        checks++; if (resp[3] !== 8'hFF) begin errors++; $display("FAIL snap_b0 got %h want ff", resp[3]); end
        checks++; if (resp[4] !== 8'hFF) begin errors++; $display("FAIL snap_b1 got %h want ff", resp[4]); end
        run_poll();
        checks++; if (resp[3] !== 8'h06) begin errors++; $display("FAIL snap_next_b0 got %h want 06", resp[3]); end
        checks++; if (resp[4] !== 8'h03) begin errors++; $display("FAIL snap_next_b1 got %h want 03", resp[4]); end
        snes_buttons = 12'h000;
    endtask

    task automatic test_abort();
        logic [7:0] d;
        bit s; int dl, w;
        bit low;
        std_cmd();
        // Mid-byte abort after 4 bits of byte 1.
        @(negedge clk); ds_cs = 1'b0;
        repeat (HALF) @(negedge clk);
        xfer_bits(8'h01, 8, d);
        wait_ack(s, dl, w);
        xfer_bits(8'h42, 4, d);
        repeat (HALF) @(negedge clk);
        ds_cs = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (ds_ack !== 1'b1)     begin errors++; $display("FAIL abort_bit_ack got %b want 1", ds_ack); end
        checks++; if (ds_miso_oe !== 1'b0) begin errors++; $display("FAIL abort_bit_oe got %b want 0", ds_miso_oe); end
        repeat (5) @(negedge clk);
        run_poll();
        checks++; if (resp[0] !== 8'hFF) begin errors++; $display("FAIL abort_bit_next0 got %h want ff", resp[0]); end
        checks++; if (resp[1] !== ID)    begin errors++; $display("FAIL abort_bit_next1 got %h want %h", resp[1], ID); end
        // Abort while ACK is low.
        @(negedge clk); ds_cs = 1'b0;
        repeat (HALF) @(negedge clk);
        xfer_bits(8'h01, 8, d);
        low = 1'b0;
        for (int i = 0; i < ACK_DELAY + 12 && !low; i++) begin
            @(negedge clk);
            if (ds_ack === 1'b0) low = 1'b1;
        end
        checks++; if (low !== 1'b1) begin errors++; $display("FAIL abort_ack_timeout got %0d want 1", low); end
        ds_cs = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (ds_ack !== 1'b1)     begin errors++; $display("FAIL abort_ack_ack got %b want 1", ds_ack); end
        checks++; if (ds_miso_oe !== 1'b0) begin errors++; $display("FAIL abort_ack_oe got %b want 0", ds_miso_oe); end
        repeat (5) @(negedge clk);
        run_poll();
        checks++; if (resp[1] !== ID)    begin errors++; $display("FAIL abort_ack_next1 got %h want %h", resp[1], ID); end
        checks++; if (resp[2] !== 8'h5A) begin errors++; $display("FAIL abort_ack_next2 got %h want 5a", resp[2]); end
    endtask

    task automatic test_ack_violation();
        std_cmd();
        early_idx = 0;
        run_poll();
        early_idx = -1;
        checks++; if (resp[1] !== ID)    begin errors++; $display("FAIL viol_dat1 got %h want %h", resp[1], ID); end
        checks++; if (resp[2] !== 8'h5A) begin errors++; $display("FAIL viol_dat2 got %h want 5a", resp[2]); end
        checks++; if (ack_seen[1] !== 1'b1) begin errors++; $display("FAIL viol_ack1 got %0d want 1", ack_seen[1]); end
        checks++; if (ack_w[1] != ACK_WIDTH) begin errors++; $display("FAIL viol_ackw1 got %0d want %0d", ack_w[1], ACK_WIDTH); end
    endtask

    task automatic test_back_to_back();
        std_cmd();
        snes_buttons = 12'h811;
        run_poll();
        snes_buttons = 12'h004;
        run_poll();
        checks++; if (resp[3] !== 8'hFE) begin errors++; $display("FAIL b2b_b0 got %h want fe", resp[3]); end
        checks++; if (resp[4] !== 8'hFF) begin errors++; $display("FAIL b2b_b1 got %h want ff", resp[4]); end
        snes_buttons = 12'h000;
    endtask

    task automatic test_reset_midframe();
        logic [7:0] d;
        bit low, s; int dl, w;
        std_cmd();
        @(negedge clk); ds_cs = 1'b0;
        repeat (HALF) @(negedge clk);
        xfer_bits(8'h01, 8, d);
        low = 1'b0;
        for (int i = 0; i < ACK_DELAY + 12 && !low; i++) begin
            @(negedge clk);
            if (ds_ack === 1'b0) low = 1'b1;
        end
        checks++; if (low !== 1'b1) begin errors++; $display("FAIL rst_mid_timeout got %0d want 1", low); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if (ds_ack !== 1'b1)     begin errors++; $display("FAIL rst_mid_ack got %b want 1", ds_ack); end
        checks++; if (ds_miso_oe !== 1'b0) begin errors++; $display("FAIL rst_mid_oe got %b want 0", ds_miso_oe); end
        checks++; if (ds_miso !== 1'b1)    begin errors++; $display("FAIL rst_mid_miso got %b want 1", ds_miso); end
        reset = 1'b0;
        repeat (HALF) @(negedge clk);
        xfer_bits(8'h01, 8, d);
        wait_ack(s, dl, w);
        checks++; if (s !== 1'b0)          begin errors++; $display("FAIL rst_low_bus_ack got %0d want 0", s); end
        checks++; if (ds_miso_oe !== 1'b0) begin errors++; $display("FAIL rst_low_bus_oe got %b want 0", ds_miso_oe); end
        ds_cs = 1'b1;
        repeat (8) @(negedge clk);
        run_poll();
        checks++; if (resp[1] !== ID) begin errors++; $display("FAIL rst_recover_id got %h want %h", resp[1], ID); end
    endtask

    initial begin
        reset        = 1'b1;
        snes_buttons = 12'h000;
        ds_cs        = 1'b1;
        ds_clk       = 1'b1;
        ds_mosi      = 1'b1;
        test_reset();
        test_idle_poll();
        test_button_mapping();
        test_bad_address();
        test_snapshot();
        test_abort();
        test_ack_violation();
        test_back_to_back();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
